// File: rtl/tile_move_engine.sv
// Live 4x4 sliding-puzzle board: loads an initial layout, then applies one blank-tile move
// per accepted request through a READ/WRITE/CHECK sequence.
module tile_move_engine #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [63:0]      board_in,
  input  logic [5:0]       blank_in,
  input  logic             move_valid,
  input  logic [1:0]       move_dir,
  output logic             move_ready,
  output logic [63:0]      board_out,
  output logic [5:0]       blank_out,
  output logic [CNT_W-1:0] move_count,
  output logic             solved,
  output logic             redraw,
  output logic             error
);

  localparam logic [63:0] Goal = 64'h0FED_CBA9_8765_4321;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StCheck} state_e;

  state_e     state_q;
  logic       loaded_q;
  logic [3:0] tgt_q;
  logic [3:0] tile_q;

  logic [3:0] pos;
  logic [3:0] tgt;
  logic       legal;
  logic       load_ok;

  assign move_ready = (state_q == StIdle) && loaded_q && !solved;
  assign load_ok    = (blank_in != 6'd0) && (blank_in <= 6'd16);

  // Blank positions 1..16 map onto 0..15 through 4-bit wraparound (16 -> 0 -> 15).
  assign pos = blank_out[3:0] - 4'd1;

  always_comb begin
    legal = 1'b0;
    tgt   = pos;
    unique case (move_dir)
      2'b00: begin
        legal = pos >= 4'd4;
        tgt   = pos - 4'd4;
      end
      2'b01: begin
        legal = pos <= 4'd11;
        tgt   = pos + 4'd4;
      end
      2'b10: begin
        legal = pos[1:0] != 2'b00;
        tgt   = pos - 4'd1;
      end
      2'b11: begin
        legal = pos[1:0] != 2'b11;
        tgt   = pos + 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      loaded_q   <= 1'b0;
      tgt_q      <= 4'd0;
      tile_q     <= 4'd0;
      board_out  <= 64'd0;
      blank_out  <= 6'd0;
      move_count <= '0;
      solved     <= 1'b0;
      redraw     <= 1'b0;
      error      <= 1'b0;
    end else begin
      redraw <= 1'b0;
      error  <= 1'b0;
      if (load && load_ok) begin
        // A valid load aborts any move in flight; its write never happens.
        board_out  <= board_in;
        blank_out  <= blank_in;
        move_count <= '0;
        loaded_q   <= 1'b1;
        solved     <= 1'b0;
        state_q    <= StCheck;
      end else begin
        if (load) begin
          error <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            if (move_valid && move_ready) begin
              if (legal) begin
                tgt_q   <= tgt;
                state_q <= StRead;
              end else begin
                error <= 1'b1;
              end
            end
          end
          StRead: begin
            tile_q  <= board_out[{tgt_q, 2'b00} +: 4];
            state_q <= StWrite;
          end
          StWrite: begin
            board_out[{pos, 2'b00} +: 4]   <= tile_q;
            board_out[{tgt_q, 2'b00} +: 4] <= 4'd0;
            blank_out                      <= {2'b00, tgt_q} + 6'd1;
            if (move_count != '1) begin
              move_count <= move_count + CNT_W'(1);
            end
            state_q <= StCheck;
          end
          StCheck: begin
            solved  <= (board_out == Goal);
            redraw  <= 1'b1;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_move_engine.sv
// Randomized bench for tile_move_engine against a row/column puzzle model; a second instance
// with a 2-bit counter exercises move-count saturation.
module tb_tile_move_engine;

  localparam logic [63:0] GOAL = 64'h0FED_CBA9_8765_4321;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] board_in;
  logic [5:0]  blank_in;
  logic        move_valid;
  logic [1:0]  move_dir;

  logic        move_ready, solved, redraw, error;
  logic [63:0] board_out;
  logic [5:0]  blank_out;
  logic [9:0]  move_count;

  logic        s_move_ready, s_solved, s_redraw, s_error;
  logic [63:0] s_board_out;
  logic [5:0]  s_blank_out;
  logic [1:0]  s_move_count;

  tile_move_engine dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .board_in   (board_in),
    .blank_in   (blank_in),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .board_out  (board_out),
    .blank_out  (blank_out),
    .move_count (move_count),
    .solved     (solved),
    .redraw     (redraw),
    .error      (error)
  );

  tile_move_engine #(.CNT_W(2)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .board_in   (board_in),
    .blank_in   (blank_in),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (s_move_ready),
    .board_out  (s_board_out),
    .blank_out  (s_blank_out),
    .move_count (s_move_count),
    .solved     (s_solved),
    .redraw     (s_redraw),
    .error      (s_error)
  );

  always #5 clk = ~clk;

  // Reference model: tile values by position, 1-based blank, raw move total.
  int tiles[16];
  int mblank;
  int mcount;
  bit msolved;
  bit mloaded;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack();
    logic [63:0] b;
    b = 64'd0;
    for (int k = 0; k < 16; k++) b[4*k +: 4] = tiles[k][3:0];
    return b;
  endfunction

  // Target position of the blank after a move, or -1 if it would leave the grid.
  function automatic int target(input int p, input int dir);
    int r, c;
    r = p / 4;
    c = p % 4;
    case (dir)
      0: r = r - 1;
      1: r = r + 1;
      2: c = c - 1;
      default: c = c + 1;
    endcase
    if (r < 0 || r > 3 || c < 0 || c > 3) return -1;
    return r * 4 + c;
  endfunction

  task automatic check_outputs(input string tag, input bit exp_ready);
    int big_cnt, small_cnt;
    big_cnt   = (mcount > 1023) ? 1023 : mcount;
    small_cnt = (mcount > 3) ? 3 : mcount;
    check({tag, ".board"}, board_out, pack());
    check({tag, ".s_board"}, s_board_out, pack());
    check({tag, ".blank"}, 64'(blank_out), 64'(mblank));
    check({tag, ".count"}, 64'(move_count), 64'(big_cnt));
    check({tag, ".s_count"}, 64'(s_move_count), 64'(small_cnt));
    check({tag, ".solved"}, 64'(solved), 64'(msolved));
    check({tag, ".ready"}, 64'(move_ready), 64'(exp_ready));
  endtask

  task automatic start_move(input int dir);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'(dir);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
  endtask

  task automatic do_move(input string tag, input int dir);
    bit ready_exp;
    int p, t;
    ready_exp = mloaded && !msolved;
    p = mblank - 1;
    start_move(dir);
    if (!ready_exp) begin
      check({tag, ".ign_err"}, 64'(error), 64'd0);
      check_outputs({tag, ".ign0"}, 1'b0);
      repeat (3) begin
        @(posedge clk);
        #1;
        check({tag, ".ign_redraw"}, 64'(redraw), 64'd0);
      end
      check_outputs({tag, ".ign3"}, 1'b0);
      return;
    end
    t = target(p, dir);
    if (t < 0) begin
      check({tag, ".ill_err"}, 64'(error), 64'd1);
      check_outputs({tag, ".ill"}, 1'b1);
      @(posedge clk);
      #1;
      check({tag, ".ill_err_end"}, 64'(error), 64'd0);
      check({tag, ".ill_redraw"}, 64'(redraw), 64'd0);
      return;
    end
    check({tag, ".err"}, 64'(error), 64'd0);
    check_outputs({tag, ".e0"}, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tiles[p] = tiles[t];
    tiles[t] = 0;
    mblank   = t + 1;
    mcount++;
    check_outputs({tag, ".e2"}, 1'b0);
    check({tag, ".e2_redraw"}, 64'(redraw), 64'd0);
    @(posedge clk);
    #1;
    msolved = (pack() == GOAL);
    check({tag, ".e3_redraw"}, 64'(redraw), 64'd1);
    check_outputs({tag, ".e3"}, !msolved);
    @(posedge clk);
    #1;
    check({tag, ".e4_redraw"}, 64'(redraw), 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [63:0] b, input int blank,
                         input bit with_move);
    @(negedge clk);
    load       = 1'b1;
    board_in   = b;
    blank_in   = 6'(blank);
    move_valid = with_move;
    move_dir   = 2'($urandom_range(3));
    @(posedge clk);
    #1;
    load       = 1'b0;
    move_valid = 1'b0;
    if (blank >= 1 && blank <= 16) begin
      for (int k = 0; k < 16; k++) tiles[k] = int'(b[4*k +: 4]);
      mblank  = blank;
      mcount  = 0;
      mloaded = 1'b1;
      msolved = 1'b0;
      check({tag, ".err"}, 64'(error), 64'd0);
      check_outputs({tag, ".l0"}, 1'b0);
      @(posedge clk);
      #1;
      msolved = (pack() == GOAL);
      check({tag, ".redraw"}, 64'(redraw), 64'd1);
      check_outputs({tag, ".l1"}, !msolved);
      @(posedge clk);
      #1;
      check({tag, ".redraw_end"}, 64'(redraw), 64'd0);
    end else begin
      check({tag, ".bad_err"}, 64'(error), 64'd1);
      check({tag, ".bad_redraw"}, 64'(redraw), 64'd0);
      check_outputs({tag, ".bad"}, mloaded && !msolved);
      @(posedge clk);
      #1;
      check({tag, ".bad_err_end"}, 64'(error), 64'd0);
    end
  endtask

  task automatic random_board(output logic [63:0] b, output int blank);
    int perm[16];
    int j, tmp;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    b = 64'd0;
    blank = 1;
    for (int i = 0; i < 16; i++) begin
      b[4*i +: 4] = 4'(perm[i]);
      if (perm[i] == 0) blank = i + 1;
    end
  endtask

  initial begin
    logic [63:0] b;
    int          bl;
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    load       = 1'b0;
    board_in   = 64'd0;
    blank_in   = 6'd0;
    move_valid = 1'b0;
    move_dir   = 2'd0;
    for (int k = 0; k < 16; k++) tiles[k] = 0;
    mblank  = 0;
    mcount  = 0;
    msolved = 1'b0;
    mloaded = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0);
    check("reset.redraw", 64'(redraw), 64'd0);
    check("reset.error", 64'(error), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Moves before any load are ignored.
    do_move("noload_up", 0);
    do_move("noload_right", 3);

    do_load("goal", GOAL, 16, 1'b0);
    check("goal.solved", 64'(solved), 64'd1);
    do_move("locked", 2);

    do_load("near", 64'hF0ED_CBA9_8765_4321, 15, 1'b0);
    do_move("finish_right", 3);
    check("finish.solved", 64'(solved), 64'd1);

    do_load("corner", 64'h0FED_CBA9_8765_4312, 16, 1'b0);
    do_move("corner_right", 3);
    do_move("corner_down", 1);

    do_load("blank0", 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
    do_load("blank17", 64'h1234_5678_9ABC_DEF0, 17, 1'b0);

    // A valid load landing while a move sits in READ aborts the move.
    start_move(2);
    do_load("abort", 64'h1234_5678_9AB0_CDEF, 5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("abort.after", 1'b1);

    // Load and move in the same cycle: the load wins.
    do_load("collide", 64'h0FED_CBA9_8765_4312, 16, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("collide.after", 1'b1);

    // Counter saturation on the 2-bit instance.
    for (int k = 0; k < 15; k++) tiles[k] = k + 1;
    tiles[15] = tiles[5];
    tiles[5]  = 0;
    do_load("sat", pack(), 6, 1'b0);
    for (int i = 0; i < 5; i++) do_move("sat_mv", (i % 2 == 0) ? 0 : 1);

    // Randomized boards and moves, with occasional rejected loads.
    for (int g = 0; g < 4; g++) begin
      random_board(b, bl);
      do_load("rnd_load", b, bl, 1'b0);
      for (int m = 0; m < 25; m++) begin
        if ($urandom_range(19) == 0) begin
          do_load("rnd_bad", b, ($urandom_range(1) == 0) ? 0 : int'($urandom_range(63, 17)),
                  1'b0);
        end else begin
          do_move("rnd_mv", int'($urandom_range(3)));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
